// File: rtl/sort_div_pkg.sv
// Shared types and constants for the serial sort/divide engine.
package sort_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BUILD,
    DIVIDE,
    OUTPUT
  } state_t;

  localparam logic [3:0] EXCESS_OFS = 4'd3;
  localparam logic [3:0] MIN_CODE   = 4'd3;
  localparam logic [3:0] MAX_CODE   = 4'd12;

  // True when an excess-3 code maps to a decimal digit 0..9.
  function automatic logic is_legal(input logic [3:0] code);
    return (code >= MIN_CODE) && (code <= MAX_CODE);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: DVD_W-bit dividend by 4-bit divisor, one quotient bit per cycle.
// The start cycle already performs the first step, so done pulses DVD_W cycles
// after start. A zero divisor naturally produces an all-ones quotient.
module seq_divider #(
  parameter int unsigned DVD_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [3:0]       divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [3:0]       remainder
);

  localparam int unsigned CW = $clog2(DVD_W + 1);

  logic [CW-1:0]    cnt;
  logic [DVD_W-1:0] src_q;
  logic [3:0]       src_r;
  logic [4:0]       trial;
  logic [4:0]       diff;
  logic             fits;

  // One restoring step; on start the operands come straight from the inputs.
  always_comb begin
    src_q = start ? dividend : quotient;
    src_r = start ? '0 : remainder;
    trial = {src_r, src_q[DVD_W-1]};
    fits  = trial >= {1'b0, divisor};
    diff  = fits ? (trial - {1'b0, divisor}) : trial;
  end

  // Iteration registers and start/busy/done handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        quotient  <= {src_q[DVD_W-2:0], fits};
        remainder <= diff[3:0];
      end
      if (start) begin
        cnt  <= CW'(DVD_W - 1);
        busy <= 1'b1;
      end else if (busy) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sort_div_serial.sv
// Serial excess-3 digit sorter / divider with fixed latency.
// Digits are insertion-sorted on arrival, the non-divisor digits are folded into a
// decimal dividend, divided by the digit at DIV_POS, and the quotient or remainder
// is shifted out MSB first.
module sort_div_serial #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIV_POS  = 1,
  parameter int unsigned DVD_W    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic       in_mode,
  output logic       out_valid,
  output logic       out_data,
  output logic       out_err
);

  import sort_div_pkg::*;

  localparam int unsigned KW = $clog2(N_DIGITS + 1);
  localparam int unsigned BW = $clog2(DVD_W + 1);

  state_t state, state_nxt;

  logic [3:0]       digits     [N_DIGITS];
  logic [3:0]       sorted_nxt [N_DIGITS];
  logic [3:0]       shifted    [N_DIGITS];
  logic [KW-1:0]    nload;
  logic [KW-1:0]    filled;
  logic [KW-1:0]    bidx;
  logic [KW-1:0]    build_idx;
  logic [BW-1:0]    ocnt;
  logic             mode;
  logic             err;
  logic             capture;
  logic             ge;
  logic             prev_ge;
  logic [3:0]       in_digit;
  logic [3:0]       build_digit;
  logic [3:0]       divisor;
  logic [DVD_W-1:0] acc;
  logic [DVD_W-1:0] acc_nxt;
  logic [DVD_W-1:0] shreg;
  logic [DVD_W-1:0] result;

  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [DVD_W-1:0] div_quot;
  logic [3:0]       div_rem;

  assign in_digit = is_legal(in_data) ? (in_data - EXCESS_OFS) : '0;
  assign divisor  = digits[DIV_POS];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and per-cycle control strobes.
  // The divider is started in the last BUILD cycle on the combinational accumulator
  // value, so the DVD_W division steps end exactly as DIVIDE does.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    div_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (!in_valid) begin
          state_nxt = IDLE;
        end else begin
          capture = 1'b1;
          if (nload == KW'(N_DIGITS - 1)) state_nxt = BUILD;
        end
      end
      BUILD: begin
        if (bidx == KW'(N_DIGITS - 2)) begin
          div_start = !div_busy;
          state_nxt = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (ocnt == BW'(DVD_W - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Descending insertion: the new digit lands after every stored digit >= it,
  // which keeps equal digits in arrival order.
  always_comb begin
    filled     = (state == LOAD) ? nload : '0;
    shifted[0] = '0;
    for (int unsigned i = 1; i < N_DIGITS; i++) shifted[i] = digits[i-1];
    ge      = 1'b0;
    prev_ge = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      ge = (KW'(i) < filled) && (digits[i] >= in_digit);
      if (ge)           sorted_nxt[i] = digits[i];
      else if (prev_ge) sorted_nxt[i] = in_digit;
      else              sorted_nxt[i] = shifted[i];
      prev_ge = ge;
    end
  end

  // Dividend accumulation, largest digit first, stepping over the divisor slot.
  always_comb begin
    build_idx   = (bidx < KW'(DIV_POS)) ? bidx : (bidx + 1'b1);
    build_digit = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++)
      if (build_idx == KW'(i)) build_digit = digits[i];
    acc_nxt = (acc << 3) + (acc << 1) + DVD_W'(build_digit);
  end

  // Result selection: illegal input or zero divisor saturates to all-ones.
  always_comb begin
    if (err || (divisor == '0)) result = '1;
    else if (mode)              result = DVD_W'(div_rem);
    else                        result = div_quot;
  end

  // Digit store, transaction flags, accumulator and output shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= '{default: '0};
      nload  <= '0;
      bidx   <= '0;
      ocnt   <= '0;
      mode   <= 1'b0;
      err    <= 1'b0;
      acc    <= '0;
      shreg  <= '0;
    end else begin
      if (capture) begin
        digits <= sorted_nxt;
        nload  <= (state == IDLE) ? KW'(1) : (nload + 1'b1);
        if (state == IDLE) begin
          mode <= in_mode;
          err  <= !is_legal(in_data);
        end else begin
          err  <= err | !is_legal(in_data);
        end
      end
      if (state == BUILD) begin
        acc  <= acc_nxt;
        bidx <= bidx + 1'b1;
      end else begin
        acc  <= '0;
        bidx <= '0;
      end
      if (state == DIVIDE && div_done) begin
        shreg <= result;
        ocnt  <= '0;
      end else if (state == OUTPUT) begin
        shreg <= {shreg[DVD_W-2:0], 1'b0};
        ocnt  <= ocnt + 1'b1;
      end
    end
  end

  seq_divider #(.DVD_W(DVD_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (acc_nxt),
    .divisor   (divisor),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  assign out_valid = (state == OUTPUT);
  assign out_data  = out_valid & shreg[DVD_W-1];
  assign out_err   = out_valid & err;

endmodule

// File: tb/tb_sort_div_serial.sv
// Scoreboard bench: dut_a uses the default 4-digit/10-bit build, dut_b a 3-digit/7-bit build.
module tb_sort_div_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] iv, im, ov, od, oe;
  logic [3:0] ida, idb;

  always #5 clk = ~clk;

  sort_div_serial #(.N_DIGITS(4), .DIV_POS(1), .DVD_W(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(ida), .in_mode(im[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_err(oe[0])
  );

  sort_div_serial #(.N_DIGITS(3), .DIV_POS(1), .DVD_W(7)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(idb), .in_mode(im[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_err(oe[1])
  );

  typedef struct {
    int         dut;
    logic [9:0] val;
    logic       err;
    int         rise;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_t = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nd(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int wd(input int d);
    return (d == 0) ? 10 : 7;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: reassembles each serial burst and compares it with the queue head.
  int         bcnt  [2];
  logic [9:0] got   [2];
  logic       eand  [2];
  logic       eor   [2];
  int         rise  [2];
  int         ovcnt [2];

  initial begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      bcnt[d] = 0; ovcnt[d] = 0; got[d] = '0; eand[d] = 1'b1; eor[d] = 1'b0; rise[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          bcnt[d] = 0;
        end else if (ov[d]) begin
          ovcnt[d]++;
          if (bcnt[d] == 0) begin
            rise[d] = cyc; got[d] = '0; eand[d] = 1'b1; eor[d] = 1'b0;
          end
          got[d]  = {got[d][8:0], od[d]};
          eand[d] = eand[d] & oe[d];
          eor[d]  = eor[d] | oe[d];
          bcnt[d]++;
          if (bcnt[d] == wd(d)) begin
            bcnt[d] = 0;
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_output: dut %0d produced %0d with nothing expected", d, got[d]);
            end else begin
              e = sb.pop_front();
              check("dut_id", 32'(d), 32'(e.dut));
              check("data", 32'(got[d]), 32'(e.val));
              check("err_flag", {30'd0, eor[d], eand[d]}, {30'd0, e.err, e.err});
              check("latency", 32'(rise[d]), 32'(e.rise));
            end
          end
        end else begin
          check("idle_quiet", {30'd0, od[d], oe[d]}, 32'd0);
          if (bcnt[d] != 0) begin
            check("burst_length", 32'(bcnt[d]), 32'(wd(d)));
            bcnt[d] = 0;
          end
        end
      end
    end
  end

  task automatic drive(input int d, input logic v, input logic [3:0] c, input logic m);
    if (d == 0) begin iv[0] = v; ida = c; im[0] = m; end
    else        begin iv[1] = v; idb = c; im[1] = m; end
  endtask

  // codes: nibble i is the i-th digit sent; mode toggles after the first digit
  // to show it is only sampled once.
  task automatic send(input int d, input logic [23:0] codes, input logic mode,
                      input logic [9:0] expv, input logic experr, input bit extra);
    exp_t e;
    for (int i = 0; i < nd(d); i++) begin
      drive(d, 1'b1, codes[4*i +: 4], (i == 0) ? mode : ~mode);
      last_t = cyc;
      @(posedge clk); #1;
    end
    e.dut = d; e.val = expv; e.err = experr; e.rise = last_t + nd(d) + wd(d);
    sb.push_back(e);
    if (extra) begin
      repeat (3) begin
        drive(d, 1'b1, 4'd0, ~mode);
        @(posedge clk); #1;
      end
    end
    drive(d, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic wait_gap(input int d, input int gap);
    while (cyc < last_t + nd(d) + 2 * wd(d) + gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic directed(input int d);
    logic [9:0] ones;
    int         base;
    ones = (d == 0) ? 10'h3FF : 10'h07F;
    // 9,4,7,2 -> 942/7 = 134 r4 ; 3-digit: 9,4,7 -> 94/7 = 13 r3
    send(d, 24'h005A7C, 1'b0, (d == 0) ? 10'd134 : 10'd13, 1'b0, 1'b0); wait_gap(d, 2);
    send(d, 24'h005A7C, 1'b1, (d == 0) ? 10'd4 : 10'd3, 1'b0, 1'b1);    wait_gap(d, 3);
    // zero divisor
    send(d, 24'h003338, 1'b0, ones, 1'b0, 1'b0); wait_gap(d, 2);
    send(d, 24'h003338, 1'b1, ones, 1'b0, 1'b0); wait_gap(d, 4);
    // all nines: 999/9 = 111 r0 ; 99/9 = 11 r0
    send(d, 24'h00CCCC, 1'b0, (d == 0) ? 10'd111 : 10'd11, 1'b0, 1'b0); wait_gap(d, 2);
    send(d, 24'h00CCCC, 1'b1, 10'd0, 1'b0, 1'b0); wait_gap(d, 0);
    // illegal code 1
    send(d, 24'h00571C, 1'b0, ones, 1'b1, 1'b0); wait_gap(d, 2);
    send(d, 24'h00571C, 1'b1, ones, 1'b1, 1'b0); wait_gap(d, 2);
    // short burst aborts silently
    base = ovcnt[d];
    drive(d, 1'b1, 4'd12, 1'b0); @(posedge clk); #1;
    drive(d, 1'b1, 4'd7, 1'b0);  @(posedge clk); #1;
    drive(d, 1'b0, 4'd0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_output", 32'(ovcnt[d] - base), 32'd0);
    send(d, 24'h005A7C, 1'b0, (d == 0) ? 10'd134 : 10'd13, 1'b0, 1'b0); wait_gap(d, 2);
    // reset in the middle of OUTPUT
    send(d, 24'h00CCCC, 1'b0, (d == 0) ? 10'd111 : 10'd11, 1'b0, 1'b0);
    for (int i = 0; i < 60 && !ov[d]; i++) begin
      @(posedge clk); #1;
    end
    check("reset_test_started", 32'(ov[d]), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("reset_async", {29'd0, ov[d], od[d], oe[d]}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(d, 24'h005A7C, 1'b1, (d == 0) ? 10'd4 : 10'd3, 1'b0, 1'b0); wait_gap(d, 2);
  endtask

  function automatic logic [23:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {8'h00, 4'(x3 + 3), 4'(x2 + 3), 4'(x1 + 3), 4'(x0 + 3)};
  endfunction

  // Every descending 4-digit multiset, sent in rotating permutations.
  task automatic sweep();
    int          k, dv, dd;
    logic        m;
    logic [9:0]  ex;
    logic [23:0] codes;
    k = 0;
    for (int a = 0; a < 10; a++)
      for (int b = 0; b <= a; b++)
        for (int c = 0; c <= b; c++)
          for (int e = 0; e <= c; e++) begin
            dv = b;
            dd = a * 100 + c * 10 + e;
            m  = (k % 2) == 1;
            if (dv == 0) ex = 10'h3FF;
            else if (m)  ex = 10'(dd % dv);
            else         ex = 10'(dd / dv);
            case (k % 4)
              0:       codes = pack4(a, b, c, e);
              1:       codes = pack4(e, c, b, a);
              2:       codes = pack4(c, a, e, b);
              default: codes = pack4(b, e, a, c);
            endcase
            send(0, codes, m, ex, 1'b0, 1'b0);
            wait_gap(0, 2 + (k % 5));
            k++;
          end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    iv = '0; im = '0; ida = '0; idb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {26'd0, ov, od, oe}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    directed(0);
    sweep();
    directed(1);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    check("pending_results", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
